register_file: RTL and testbench

- General-purpose register file for the 16-bit CPU datapath: 16 registers x 16 bits.
- Two asynchronous (combinational) read ports feed the ALU operands; one synchronous write port is driven from writeback.
- Sits between decode (source/destination specifiers) and execute/writeback.

---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_word.sv | 22 ++
 rtl/register_file.sv | 71 +++++++
 tb/tb_register_file.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared sizing and types for the CPU general-purpose register file.
package regfile_pkg;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/regfile_word.sv
// One register-file word: DATA_W-bit register with async active-high clear
// and a write enable.
module regfile_word
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      wrEn,
    input  reg_data_t wrData,
    output reg_data_t q
);

    // Clear immediately on rst; otherwise capture write data when selected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (wrEn) begin
            q <= wrData;
        end
    end

endmodule

// File: rtl/register_file.sv
// 16 x 16 general-purpose register file: two combinational read ports with
// write-before-read bypass, one synchronous write port.
// Build option: define REGFILE_ZERO_R0_EN to hardwire R0 to zero (writes to R0
// dropped, reads of R0 return 0 and are never bypassed).
module register_file
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  reg_addr_t SrcReg1,
    input  reg_addr_t SrcReg2,
    input  reg_addr_t DstReg,
    input  logic      WriteReg,
    input  reg_data_t DstData,
    output reg_data_t SrcData1,
    output reg_data_t SrcData2
);

    logic [NUM_REGS-1:0]             writeSel;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;

    // One-hot write decode, gated by the write enable.
    always_comb begin
        writeSel = '0;
        if (WriteReg) begin
            writeSel[DstReg] = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : gWord
`ifdef REGFILE_ZERO_R0_EN
        if (g == 0) begin : gZero
            assign regs[g] = '0;
        end else begin : gReg
            regfile_word uWord (
                .clk    (clk),
                .rst    (rst),
                .wrEn   (writeSel[g]),
                .wrData (DstData),
                .q      (regs[g])
            );
        end
`else
        regfile_word uWord (
            .clk    (clk),
            .rst    (rst),
            .wrEn   (writeSel[g]),
            .wrData (DstData),
            .q      (regs[g])
        );
`endif
    end

    // Hit when the in-flight write targets the read register. The bypass is
    // deliberately independent of rst so writeback data forwards even then.
    logic hit1, hit2;
`ifdef REGFILE_ZERO_R0_EN
    assign hit1 = WriteReg && (DstReg == SrcReg1) && (DstReg != '0);
    assign hit2 = WriteReg && (DstReg == SrcReg2) && (DstReg != '0);
`else
    assign hit1 = WriteReg && (DstReg == SrcReg1);
    assign hit2 = WriteReg && (DstReg == SrcReg2);
`endif

    // Read muxes with write-before-read forwarding.
    always_comb begin
        SrcData1 = hit1 ? DstData : regs[SrcReg1];
        SrcData2 = hit2 ? DstData : regs[SrcReg2];
    end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected read data,
// a negedge monitor pops and compares against the combinational outputs.
module tb_register_file;
    import regfile_pkg::*;

`ifdef REGFILE_ZERO_R0_EN
    localparam bit ZeroR0 = 1'b1;
`else
    localparam bit ZeroR0 = 1'b0;
`endif

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    reg_addr_t SrcReg1 = '0, SrcReg2 = '0, DstReg = '0;
    logic      WriteReg = 1'b0;
    reg_data_t DstData = '0;
    reg_data_t SrcData1, SrcData2;

    register_file dut (
        .clk      (clk),
        .rst      (rst),
        .SrcReg1  (SrcReg1),
        .SrcReg2  (SrcReg2),
        .DstReg   (DstReg),
        .WriteReg (WriteReg),
        .DstData  (DstData),
        .SrcData1 (SrcData1),
        .SrcData2 (SrcData2)
    );

    always #5 clk = ~clk;

    typedef struct {
        string     name;
        int        s1;
        int        s2;
        logic [15:0] e1;
        logic [15:0] e2;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] model [16];
    int          errors = 0;
    int          checks = 0;

    // Reference read: R0 hardwired when enabled, else bypass, else stored value.
    function automatic logic [15:0] refRead(int s, logic we, int d, logic [15:0] data);
        if (ZeroR0 && s == 0) return 16'h0000;
        if (we && d == s)     return data;
        return model[s];
    endfunction

    // One cycle of stimulus: drive just after a rising edge, record expectation,
    // then let the next rising edge commit the write into the model.
    task automatic step(input string nm, input logic r, input logic we, input int d,
                        input logic [15:0] data, input int s1, input int s2);
        exp_t e;
        rst = r; WriteReg = we; DstReg = reg_addr_t'(d); DstData = data;
        SrcReg1 = reg_addr_t'(s1); SrcReg2 = reg_addr_t'(s2);
        if (r) for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        e.name = nm; e.s1 = s1; e.s2 = s2;
        e.e1 = refRead(s1, we, d, data);
        e.e2 = refRead(s2, we, d, data);
        sbq.push_back(e);
        @(posedge clk);
        if (!r && we && !(ZeroR0 && d == 0)) model[d] = data;
        #1;
    endtask

    // Monitor: outputs are combinational, so they are valid mid-cycle.
    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            checks++;
            if (SrcData1 !== e.e1) begin
                errors++;
                $display("FAIL %s port1 R%0d: got %h expected %h", e.name, e.s1, SrcData1, e.e1);
            end
            checks++;
            if (SrcData2 !== e.e2) begin
                errors++;
                $display("FAIL %s port2 R%0d: got %h expected %h", e.name, e.s2, SrcData2, e.e2);
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        @(posedge clk); #1;

        // Reset held for two cycles, then read every register pairwise.
        step("reset_hold", 1, 0, 0, 16'h0000, 0, 15);
        step("reset_hold", 1, 0, 0, 16'h0000, 3, 9);
        for (int i = 0; i < 16; i += 2) step("reset_read", 0, 0, 0, 16'h0000, i, i + 1);

        // Basic write/read.
        step("wr_r0", 0, 1, 0, 16'hABCD, 0, 1);
        step("wr_r1", 0, 1, 1, 16'hBFF0, 0, 1);
        step("rd_0_1", 0, 0, 0, 16'h0000, 0, 1);

        // Overwrite and persistence.
        step("wr_r0b", 0, 1, 0, 16'hBEAD, 2, 4);
        step("wr_r3", 0, 1, 3, 16'hACDC, 2, 4);
        step("wr_r5", 0, 1, 5, 16'hFEED, 2, 4);
        step("rd_0_3", 0, 0, 0, 16'h0000, 0, 3);
        step("rd_1_5", 0, 0, 0, 16'h0000, 1, 5);

        // Bypass on both ports, then write-enable gating.
        step("bypass_r7", 0, 1, 7, 16'h1234, 7, 7);
        step("after_r7", 0, 0, 0, 16'h0000, 7, 7);
        for (int i = 0; i < 3; i++) step("we_gate", 0, 0, 7, 16'hFFFF, 7, 3);
        step("r7_held", 0, 0, 0, 16'h0000, 7, 5);

        // Async reset between edges, bypass while in reset, then recovery.
        step("rst_mid", 1, 0, 0, 16'h0000, 7, 3);
        step("rst_bypass", 1, 1, 9, 16'h7777, 9, 5);
        step("post_rst", 0, 0, 0, 16'h0000, 9, 0);
        step("wr_r2", 0, 1, 2, 16'h5A5A, 3, 4);
        step("rd_r2", 0, 0, 0, 16'h0000, 2, 2);

        // R0 / R15 corners (R0 result depends on the zero-R0 build).
        step("wr_r0c", 0, 1, 0, 16'hABCD, 0, 15);
        step("rd_r0", 0, 0, 0, 16'h0000, 0, 0);
        step("wr_r15", 0, 1, 15, 16'hC0DE, 1, 2);
        step("rd_r15", 0, 0, 0, 16'h0000, 15, 0);

        // Randomized traffic with frequent bypass hits and occasional reset.
        for (int n = 0; n < 400; n++) begin
            int d, s1, s2;
            logic r, we;
            d  = $urandom_range(0, 15);
            s1 = ($urandom_range(0, 3) == 0) ? d : $urandom_range(0, 15);
            s2 = ($urandom_range(0, 3) == 0) ? d : $urandom_range(0, 15);
            r  = ($urandom_range(0, 39) == 0);
            we = $urandom_range(0, 1);
            step("random", r, we, d, 16'($urandom), s1, s2);
        end

        // Everything pushed must have been consumed by the monitor.
        @(negedge clk); #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound in case stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
